iter_shift_unit: RTL and testbench

//  Multi-cycle, multi-mode shifter for the CPU datapath (shift instructions and divider pre-normalisation).

---
 rtl/shift_pkg.sv | 17 +
 rtl/shift_step.sv | 56 +++++
 rtl/iter_shift_unit.sv | 106 ++++++++++
 tb/tb_iter_shift_unit.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the iterative shifter: shift mode encoding and FSM states.
package shift_pkg;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational step shifter: shifts by k (0..STEP) positions in one of four
// modes and reports the last bit that left the word during this step.
module shift_step
    import shift_pkg::*;
#(
    parameter int N    = 16,
    parameter int STEP = 1
) (
    input  logic [N-1:0]                 data,
    input  shift_mode_e                  mode,
    input  logic [$clog2(STEP+1)-1:0]    k,
    output logic [N-1:0]                 result,
    output logic                         carry
);

    int ki;

    // Widen the step amount once so the shifts and index compares stay simple
    always_comb ki = int'(k);

    // Shift by ki per mode; carry is the last bit pushed out (ROR: new MSB)
    always_comb begin
        result = data;
        carry  = 1'b0;
        case (mode)
            SH_LSL: begin
                result = data << ki;
                for (int i = 0; i < N; i++) begin
                    if (ki != 0 && i == N - ki) carry = data[i];
                end
            end
            SH_LSR: begin
                result = data >> ki;
                for (int i = 0; i < N; i++) begin
                    if (ki != 0 && i == ki - 1) carry = data[i];
                end
            end
            SH_ASR: begin
                // The MSB never changes under ASR, so the current MSB is the original sign
                result = $signed(data) >>> ki;
                for (int i = 0; i < N; i++) begin
                    if (ki != 0 && i == ki - 1) carry = data[i];
                end
            end
            SH_ROR: begin
                result = (data >> ki) | (data << (N - ki));
                carry  = (ki != 0) & result[N-1];
            end
            default: begin
                result = data;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/iter_shift_unit.sv
// Iterative multi-mode shifter: shifts an N-bit operand by up to N-1 positions,
// at most STEP positions per cycle, with valid/ready handshakes on both sides.
module iter_shift_unit
    import shift_pkg::*;
#(
    parameter int N    = 16,
    parameter int STEP = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N-1:0]           in_data,
    input  logic [$clog2(N)-1:0]   in_amt,
    input  logic [1:0]             in_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N-1:0]           out_data,
    output logic                   out_carry,
    output logic                   busy
);

    localparam int AW = $clog2(N);
    localparam int KW = $clog2(STEP + 1);

    state_e      state, state_next;
    logic [N-1:0]  data_q;
    shift_mode_e   mode_q;
    logic [AW-1:0] rem_q;
    logic          carry_q;

    logic [KW-1:0] k;
    logic [AW-1:0] rem_after;
    logic [N-1:0]  step_data;
    logic          step_carry;

    // Per-cycle step size: the full STEP until the remainder is smaller
    always_comb begin
        if (int'(rem_q) > STEP) k = KW'(STEP);
        else                    k = KW'(rem_q);
        rem_after = rem_q - AW'(k);
    end

    shift_step #(
        .N    (N),
        .STEP (STEP)
    ) u_step (
        .data   (data_q),
        .mode   (mode_q),
        .k      (k),
        .result (step_data),
        .carry  (step_carry)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_next = (in_amt != '0) ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                if (rem_after == '0) state_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand capture at accept, then one step per SHIFT cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            mode_q  <= SH_LSL;
            rem_q   <= '0;
            carry_q <= 1'b0;
        end else if (state == ST_IDLE && in_valid) begin
            data_q  <= in_data;
            mode_q  <= shift_mode_e'(in_mode);
            rem_q   <= in_amt;
            carry_q <= 1'b0;
        end else if (state == ST_SHIFT) begin
            data_q  <= step_data;
            carry_q <= step_carry;
            rem_q   <= rem_after;
        end
    end

    assign out_data  = data_q;
    assign out_carry = carry_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed and randomised checks of iter_shift_unit; four instances with
// STEP = 1, 3, 4, 8 run in lockstep on shared inputs.
module tb_iter_shift_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] in_data;
    logic [3:0]  in_amt;
    logic [1:0]  in_mode;

    logic        in_ready  [4];
    logic        out_valid [4];
    logic        out_carry [4];
    logic        busy      [4];
    logic [15:0] out_data  [4];

    int total = 0;
    int bad   = 0;

    logic [15:0] got_d   [4];
    logic        got_c   [4];
    int          got_lat [4];

    localparam logic [1:0] LSL = 2'd0, LSR = 2'd1, ASR = 2'd2, ROR = 2'd3;

    always #5 clk = ~clk;

    iter_shift_unit #(.N(16), .STEP(1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_data(out_data[0]),
        .out_carry(out_carry[0]), .busy(busy[0]));
    iter_shift_unit #(.N(16), .STEP(3)) u_s3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_data(out_data[1]),
        .out_carry(out_carry[1]), .busy(busy[1]));
    iter_shift_unit #(.N(16), .STEP(4)) u_s4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
        .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(out_valid[2]), .out_ready(out_ready), .out_data(out_data[2]),
        .out_carry(out_carry[2]), .busy(busy[2]));
    iter_shift_unit #(.N(16), .STEP(8)) u_s8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[3]),
        .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(out_valid[3]), .out_ready(out_ready), .out_data(out_data[3]),
        .out_carry(out_carry[3]), .busy(busy[3]));

    function automatic int step_of(int i);
        case (i)
            0:       return 1;
            1:       return 3;
            2:       return 4;
            default: return 8;
        endcase
    endfunction

    // Cycles from accept edge to out_valid: 1 + ceil(amt/STEP)
    function automatic int lat_of(int i, int amt);
        if (amt == 0) return 1;
        return 1 + (amt + step_of(i) - 1) / step_of(i);
    endfunction

    // Reference: one bit at a time, amt times; returns {carry, data}
    function automatic logic [16:0] model(logic [15:0] d, int amt, logic [1:0] m);
        logic [15:0] r;
        logic        c;
        r = d;
        c = 1'b0;
        for (int s = 0; s < amt; s++) begin
            case (m)
                LSL: begin c = r[15]; r = {r[14:0], 1'b0}; end
                LSR: begin c = r[0];  r = {1'b0, r[15:1]}; end
                ASR: begin c = r[0];  r = {r[15], r[15:1]}; end
                default: r = {r[0], r[15:1]};
            endcase
        end
        if (m == ROR && amt != 0) c = r[15];
        return {c, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One transaction on all instances with out_ready held high; records
    // first-valid data, carry and latency per instance.
    task automatic do_op(input logic [15:0] d, input logic [3:0] a, input logic [1:0] m);
        bit seen [4];
        int nseen;
        int c;
        nseen = 0;
        for (int i = 0; i < 4; i++) begin
            seen[i] = 1'b0; got_lat[i] = -1; got_d[i] = 'x; got_c[i] = 1'bx;
        end
        in_data = d; in_amt = a; in_mode = m; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        c = 1;
        while (nseen < 4 && c <= 40) begin
            for (int i = 0; i < 4; i++) begin
                if (!seen[i] && out_valid[i]) begin
                    seen[i] = 1'b1; nseen++;
                    got_d[i] = out_data[i]; got_c[i] = out_carry[i]; got_lat[i] = c;
                end
            end
            if (nseen < 4) begin
                tick();
                c++;
            end
        end
        if (nseen < 4) begin
            total++; bad++;
            $display("FAIL op_timeout: got %0d of 4 results, want 4", nseen);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_amt = '0; in_mode = LSL;
        @(negedge clk);
        tick();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_valid[i] !== 1'b0 || out_data[i] !== 16'h0000 || out_carry[i] !== 1'b0 ||
                busy[i] !== 1'b0 || in_ready[i] !== 1'b1) begin
                bad++;
                $display("FAIL reset_state dut%0d: got v=%b d=%h c=%b busy=%b rdy=%b, want 0 0000 0 0 1",
                         i, out_valid[i], out_data[i], out_carry[i], busy[i], in_ready[i]);
            end
        end
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (in_ready[i] !== 1'b1 || busy[i] !== 1'b0) begin
                bad++;
                $display("FAIL post_reset_idle dut%0d: got rdy=%b busy=%b, want 1 0", i, in_ready[i], busy[i]);
            end
        end
    endtask

    task automatic test_lsr();
        do_op(16'hB00F, 4'd4, LSR);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_d[i] !== 16'h0B00 || got_c[i] !== 1'b1 || got_lat[i] !== lat_of(i, 4)) begin
                bad++;
                $display("FAIL lsr_b00f dut%0d: got d=%h c=%b lat=%0d, want d=0b00 c=1 lat=%0d",
                         i, got_d[i], got_c[i], got_lat[i], lat_of(i, 4));
            end
        end
    endtask

    task automatic test_modes();
        logic [15:0] d, ed;
        logic [3:0]  a;
        logic [1:0]  m;
        logic        ec;
        for (int v = 0; v < 7; v++) begin
            case (v)
                0: begin d = 16'h8001; a = 4'd15; m = ASR; ed = 16'hFFFF; ec = 1'b0; end
                1: begin d = 16'h8001; a = 4'd1;  m = LSL; ed = 16'h0002; ec = 1'b1; end
                2: begin d = 16'h0001; a = 4'd1;  m = ROR; ed = 16'h8000; ec = 1'b1; end
                3: begin d = 16'h1234; a = 4'd4;  m = ROR; ed = 16'h4123; ec = 1'b0; end
                4: begin d = 16'h00FF; a = 4'd12; m = LSL; ed = 16'hF000; ec = 1'b1; end
                5: begin d = 16'h7F00; a = 4'd8;  m = ASR; ed = 16'h007F; ec = 1'b0; end
                default: begin d = 16'hFFFF; a = 4'd15; m = LSR; ed = 16'h0001; ec = 1'b1; end
            endcase
            do_op(d, a, m);
            for (int i = 0; i < 4; i++) begin
                total++;
                if (got_d[i] !== ed || got_c[i] !== ec || got_lat[i] !== lat_of(i, int'(a))) begin
                    bad++;
                    $display("FAIL mode_vec%0d dut%0d: got d=%h c=%b lat=%0d, want d=%h c=%b lat=%0d",
                             v, i, got_d[i], got_c[i], got_lat[i], ed, ec, lat_of(i, int'(a)));
                end
            end
        end
    endtask

    task automatic test_zero_amt();
        for (int m = 0; m < 4; m++) begin
            do_op(16'h1234, 4'd0, 2'(m));
            for (int i = 0; i < 4; i++) begin
                total++;
                if (got_d[i] !== 16'h1234 || got_c[i] !== 1'b0 || got_lat[i] !== 1) begin
                    bad++;
                    $display("FAIL zero_amt_m%0d dut%0d: got d=%h c=%b lat=%0d, want d=1234 c=0 lat=1",
                             m, i, got_d[i], got_c[i], got_lat[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        int  c;
        bit  all_v;
        in_data = 16'hB00F; in_amt = 4'd4; in_mode = LSR; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        c = 0;
        all_v = 1'b0;
        while (!all_v && c < 20) begin
            all_v = out_valid[0] && out_valid[1] && out_valid[2] && out_valid[3];
            if (!all_v) begin tick(); c++; end
        end
        total++;
        if (!all_v) begin
            bad++;
            $display("FAIL stall_reach_done: got all_valid=0 after %0d cycles, want 1", c);
        end
        // Three held cycles with a competing request on the input
        for (int s = 0; s < 3; s++) begin
            in_data = 16'hFFFF; in_amt = 4'd1; in_mode = LSR; in_valid = 1'b1;
            tick();
            for (int i = 0; i < 4; i++) begin
                total++;
                if (out_valid[i] !== 1'b1 || in_ready[i] !== 1'b0 ||
                    out_data[i] !== 16'h0B00 || out_carry[i] !== 1'b1) begin
                    bad++;
                    $display("FAIL stall_hold%0d dut%0d: got v=%b rdy=%b d=%h c=%b, want 1 0 0b00 1",
                             s, i, out_valid[i], in_ready[i], out_data[i], out_carry[i]);
                end
            end
        end
        // Handshake with in_valid still high: result consumed, request not taken
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_valid[i] !== 1'b0 || busy[i] !== 1'b0 || in_ready[i] !== 1'b1) begin
                bad++;
                $display("FAIL stall_release dut%0d: got v=%b busy=%b rdy=%b, want 0 0 1",
                         i, out_valid[i], busy[i], in_ready[i]);
            end
        end
        // Now the held request is accepted
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (busy[i] !== 1'b1 || out_valid[i] !== 1'b0) begin
                bad++;
                $display("FAIL stall_accept dut%0d: got busy=%b v=%b, want 1 0", i, busy[i], out_valid[i]);
            end
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_valid[i] !== 1'b1 || out_data[i] !== 16'h7FFF || out_carry[i] !== 1'b1) begin
                bad++;
                $display("FAIL stall_next_result dut%0d: got v=%b d=%h c=%b, want 1 7fff 1",
                         i, out_valid[i], out_data[i], out_carry[i]);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit spurious [4];
        in_data = 16'h8001; in_amt = 4'd15; in_mode = LSL; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_valid[i] !== 1'b0 || busy[i] !== 1'b0 || in_ready[i] !== 1'b1) begin
                bad++;
                $display("FAIL mid_reset dut%0d: got v=%b busy=%b rdy=%b, want 0 0 1",
                         i, out_valid[i], busy[i], in_ready[i]);
            end
            spurious[i] = 1'b0;
        end
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < 4; i++) if (out_valid[i] !== 1'b0) spurious[i] = 1'b1;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (spurious[i]) begin
                bad++;
                $display("FAIL mid_reset_no_output dut%0d: got out_valid=1 after abort, want 0", i);
            end
        end
        do_op(16'h0001, 4'd3, LSL);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_d[i] !== 16'h0008 || got_c[i] !== 1'b0 || got_lat[i] !== lat_of(i, 3)) begin
                bad++;
                $display("FAIL after_reset_lsl dut%0d: got d=%h c=%b lat=%0d, want d=0008 c=0 lat=%0d",
                         i, got_d[i], got_c[i], got_lat[i], lat_of(i, 3));
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] d;
        logic [3:0]  a;
        logic [1:0]  m;
        logic [16:0] exp;
        bit          done [4];
        int          ndone;
        int          c;
        for (int n = 0; n < 40; n++) begin
            d = 16'($urandom);
            a = 4'($urandom_range(0, 15));
            m = 2'($urandom_range(0, 3));
            exp = model(d, int'(a), m);
            for (int i = 0; i < 4; i++) done[i] = 1'b0;
            ndone = 0;
            in_data = d; in_amt = a; in_mode = m; in_valid = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
            tick();
            in_valid = 1'b0;
            c = 0;
            while (ndone < 4 && c < 80) begin
                out_ready = (c > 30) ? 1'b1 : 1'($urandom_range(0, 1));
                for (int i = 0; i < 4; i++) begin
                    if (!done[i] && out_valid[i] && out_ready) begin
                        done[i] = 1'b1; ndone++;
                        total++;
                        if (out_data[i] !== exp[15:0] || out_carry[i] !== exp[16]) begin
                            bad++;
                            $display("FAIL random%0d dut%0d (d=%h amt=%0d mode=%0d): got d=%h c=%b, want d=%h c=%b",
                                     n, i, d, a, m, out_data[i], out_carry[i], exp[15:0], exp[16]);
                        end
                    end
                end
                tick();
                c++;
            end
            if (ndone < 4) begin
                total++; bad++;
                $display("FAIL random%0d_timeout: got %0d of 4 results, want 4", n, ndone);
            end
        end
        out_ready = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_lsr();
        test_modes();
        test_zero_amt();
        test_stall();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
